// File: rtl/na_read_rr.sv
// rtl/na_read_rr.sv - NA read engine: per-class round-robin scan, admission, truncation, bus error recovery
module na_read_rr #(
    parameter int MAX_NOC_PKT_LEN   = 10,
    parameter int NOC_FLIT_WIDTH    = 32,
    parameter int NUM_BE_ENDPOINTS  = 1,
    parameter int NUM_TDM_ENDPOINTS = 1,
    parameter int BUF_DEPTH         = 16,
    parameter int RR_MODE           = 1,
    parameter int WB_TIMEOUT        = 255
) (
    input  logic                          clk,
    input  logic                          rst_debug_n,
    input  logic                          rst_sys,
    input  logic                          irq_tdm,
    input  logic                          irq_be,
    input  logic                          enable,
    output logic                          req,
    input  logic                          wb_ack_i,
    input  logic [NOC_FLIT_WIDTH-1:0]     wb_dat_i,
    input  logic                          wb_err_i,
    output logic [31:0]                   wb_adr_o,
    output logic                          wb_cyc_o,
    output logic                          wb_stb_o,
    input  logic [$clog2(BUF_DEPTH+1)-1:0] buf_free,
    output logic [NOC_FLIT_WIDTH-1:0]     out_flit_data,
    output logic                          out_flit_valid,
    output logic                          out_flit_last,
    output logic                          out_flit_16,
    output logic                          err_pkt,
    output logic [1:0]                    err_code
);

    localparam int BF_W  = $clog2(BUF_DEPTH + 1);
    localparam int TMO_W = $clog2(WB_TIMEOUT + 1);
    localparam logic [BF_W-1:0]  ADMIT_LVL = BF_W'(MAX_NOC_PKT_LEN + 1);
    localparam logic [15:0]      MAX_LEN   = 16'(MAX_NOC_PKT_LEN);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(WB_TIMEOUT - 1);
    localparam logic [6:0]       N_TDM     = 7'(NUM_TDM_ENDPOINTS);
    localparam logic [6:0]       N_BE      = 7'(NUM_BE_ENDPOINTS);

    typedef enum logic [1:0] {S_IDLE, S_CHECK_EP, S_READ, S_DISCARD} state_t;

    state_t           r_state;
    logic             r_class_tdm;
    logic [6:0]       r_ep;
    logic [6:0]       r_scanned;
    logic [6:0]       r_last_tdm;
    logic [6:0]       r_last_be;
    logic [15:0]      r_size;
    logic [15:0]      r_cnt;
    logic [15:0]      r_fwd_len;
    logic [TMO_W-1:0] r_tmo;
    logic             r_err_pkt;
    logic [1:0]       r_err_code;

    logic             w_busy;
    logic             w_admit;
    logic             w_timeout;
    logic             w_fail;
    logic             w_hdr;
    logic [15:0]      w_size_in;
    logic [6:0]       w_n;
    logic [6:0]       w_ep_next;
    logic [6:0]       w_start_tdm;
    logic [6:0]       w_start_be;

    function automatic logic [6:0] ep_inc(input logic [6:0] ep, input logic [6:0] n);
        return (ep == n - 7'd1) ? 7'd0 : ep + 7'd1;
    endfunction

    assign w_busy      = (r_state != S_IDLE);
    assign w_admit     = (irq_tdm | irq_be) && (buf_free >= ADMIT_LVL) && !rst_sys;
    assign w_timeout   = w_busy && !wb_ack_i && !wb_err_i && (r_tmo == TMO_LAST);
    assign w_fail      = w_busy && (wb_err_i || w_timeout);
    assign w_size_in   = wb_dat_i[15:0];
    assign w_hdr       = (r_state == S_CHECK_EP) && wb_ack_i && !wb_err_i && !rst_sys
                         && (w_size_in != 16'd0);
    assign w_n         = r_class_tdm ? N_TDM : N_BE;
    assign w_ep_next   = ep_inc(r_ep, w_n);
    assign w_start_tdm = (RR_MODE != 0) ? ep_inc(r_last_tdm, N_TDM) : 7'd0;
    assign w_start_be  = (RR_MODE != 0) ? ep_inc(r_last_be, N_BE) : 7'd0;

    assign err_pkt  = r_err_pkt;
    assign err_code = r_err_code;

    // Bus and flit outputs follow the state and the current Wishbone response
    always_comb begin
        req            = 1'b0;
        wb_cyc_o       = 1'b0;
        wb_stb_o       = 1'b0;
        wb_adr_o       = '0;
        out_flit_data  = '0;
        out_flit_valid = 1'b0;
        out_flit_last  = 1'b0;
        out_flit_16    = 1'b0;
        if (w_busy) begin
            req      = 1'b1;
            wb_cyc_o = 1'b1;
            wb_stb_o = 1'b1;
            wb_adr_o = {8'd0, (r_class_tdm ? 4'd2 : 4'd1), r_ep + 7'd1, 13'd0};
        end else begin
            req = w_admit;
        end
        case (r_state)
            S_CHECK_EP: begin
                if (w_hdr) begin
                    out_flit_data  = NOC_FLIT_WIDTH'({r_class_tdm, 8'd0, r_ep});
                    out_flit_valid = 1'b1;
                    out_flit_16    = 1'b1;
                end
            end
            S_READ: begin
                // An aborted packet is closed with a zero flit so the buffer sees one last per header
                if (rst_sys || w_fail) begin
                    out_flit_valid = 1'b1;
                    out_flit_last  = 1'b1;
                end else if (wb_ack_i) begin
                    out_flit_data  = wb_dat_i;
                    out_flit_valid = 1'b1;
                    out_flit_last  = (r_cnt == r_fwd_len);
                end
            end
            default: ;
        endcase
    end

    // Scan/read FSM with bus watchdog and registered error reporting
    always_ff @(posedge clk) begin
        if (!rst_debug_n) begin
            r_state     <= S_IDLE;
            r_class_tdm <= 1'b0;
            r_ep        <= 7'd0;
            r_scanned   <= 7'd0;
            r_last_tdm  <= N_TDM - 7'd1;
            r_last_be   <= N_BE - 7'd1;
            r_size      <= 16'd0;
            r_cnt       <= 16'd0;
            r_fwd_len   <= 16'd0;
            r_tmo       <= '0;
            r_err_pkt   <= 1'b0;
            r_err_code  <= 2'd0;
        end else begin
            r_err_pkt  <= 1'b0;
            r_err_code <= 2'd0;
            if (r_state == S_IDLE || wb_ack_i || wb_err_i || rst_sys || w_timeout) begin
                r_tmo <= '0;
            end else begin
                r_tmo <= r_tmo + 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_admit && enable) begin
                        r_state     <= S_CHECK_EP;
                        r_class_tdm <= irq_tdm;
                        r_ep        <= irq_tdm ? w_start_tdm : w_start_be;
                        r_scanned   <= 7'd0;
                    end
                end
                S_CHECK_EP: begin
                    if (rst_sys) begin
                        r_state <= S_IDLE;
                    end else if (w_fail) begin
                        r_state    <= S_IDLE;
                        r_err_pkt  <= 1'b1;
                        r_err_code <= wb_err_i ? 2'd2 : 2'd3;
                    end else if (wb_ack_i) begin
                        if (w_size_in == 16'd0) begin
                            r_ep      <= w_ep_next;
                            r_scanned <= r_scanned + 7'd1;
                            if (r_scanned == w_n - 7'd1) begin
                                r_state <= S_IDLE;
                            end
                        end else begin
                            if (r_class_tdm) begin
                                r_last_tdm <= r_ep;
                            end else begin
                                r_last_be <= r_ep;
                            end
                            r_size  <= w_size_in;
                            r_cnt   <= 16'd1;
                            r_state <= S_READ;
                            if (w_size_in > MAX_LEN) begin
                                r_fwd_len  <= MAX_LEN;
                                r_err_pkt  <= 1'b1;
                                r_err_code <= 2'd1;
                            end else begin
                                r_fwd_len <= w_size_in;
                            end
                        end
                    end
                end
                S_READ: begin
                    if (rst_sys) begin
                        r_state <= S_IDLE;
                    end else if (w_fail) begin
                        r_state    <= S_IDLE;
                        r_err_pkt  <= 1'b1;
                        r_err_code <= wb_err_i ? 2'd2 : 2'd3;
                    end else if (wb_ack_i) begin
                        if (r_cnt == r_fwd_len) begin
                            if (r_size > r_fwd_len) begin
                                r_cnt   <= r_cnt + 16'd1;
                                r_state <= S_DISCARD;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_cnt <= r_cnt + 16'd1;
                        end
                    end
                end
                S_DISCARD: begin
                    if (rst_sys) begin
                        r_state <= S_IDLE;
                    end else if (w_fail) begin
                        r_state    <= S_IDLE;
                        r_err_pkt  <= 1'b1;
                        r_err_code <= wb_err_i ? 2'd2 : 2'd3;
                    end else if (wb_ack_i) begin
                        if (r_cnt == r_size) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_cnt <= r_cnt + 16'd1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_na_read_rr.sv
// tb/tb_na_read_rr.sv - directed self-checking bench for na_read_rr
module tb_na_read_rr;

    localparam int MAXL = 10;
    localparam int W    = 32;
    localparam int NBE  = 4;
    localparam int NTDM = 2;
    localparam int BD   = 16;
    localparam int TMO  = 255;

    logic          clk = 1'b0;
    logic          rst_debug_n, rst_sys, irq_tdm, irq_be, enable, req;
    logic          wb_ack_i, wb_err_i, wb_cyc_o, wb_stb_o;
    logic [W-1:0]  wb_dat_i, out_flit_data;
    logic [31:0]   wb_adr_o;
    logic [4:0]    buf_free;
    logic          out_flit_valid, out_flit_last, out_flit_16, err_pkt;
    logic [1:0]    err_code;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    na_read_rr #(
        .MAX_NOC_PKT_LEN  (MAXL),
        .NOC_FLIT_WIDTH   (W),
        .NUM_BE_ENDPOINTS (NBE),
        .NUM_TDM_ENDPOINTS(NTDM),
        .BUF_DEPTH        (BD),
        .RR_MODE          (1),
        .WB_TIMEOUT       (TMO)
    ) dut (
        .clk           (clk),
        .rst_debug_n   (rst_debug_n),
        .rst_sys       (rst_sys),
        .irq_tdm       (irq_tdm),
        .irq_be        (irq_be),
        .enable        (enable),
        .req           (req),
        .wb_ack_i      (wb_ack_i),
        .wb_dat_i      (wb_dat_i),
        .wb_err_i      (wb_err_i),
        .wb_adr_o      (wb_adr_o),
        .wb_cyc_o      (wb_cyc_o),
        .wb_stb_o      (wb_stb_o),
        .buf_free      (buf_free),
        .out_flit_data (out_flit_data),
        .out_flit_valid(out_flit_valid),
        .out_flit_last (out_flit_last),
        .out_flit_16   (out_flit_16),
        .err_pkt       (err_pkt),
        .err_code      (err_code)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [34:0] mk(input logic v, input logic l, input logic s, input logic [31:0] d);
        return {v, l, s, d};
    endfunction

    function automatic logic [34:0] flit();
        return {out_flit_valid, out_flit_last, out_flit_16, out_flit_data};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_dat_i = '0;
    endtask

    task automatic bus(input logic ack, input logic err, input logic [31:0] dat);
        wb_ack_i = ack;
        wb_err_i = err;
        wb_dat_i = dat;
        @(negedge clk);
    endtask

    task automatic start(input logic tdm);
        irq_tdm = tdm;
        irq_be  = ~tdm;
        enable  = 1'b1;
        @(negedge clk);
        chk("start_req", req, 1);
        tick();
        enable = 1'b0;
    endtask

    task automatic idle_check(input string tag, input logic ep, input logic [1:0] ec);
        irq_tdm = 1'b0;
        irq_be  = 1'b0;
        @(negedge clk);
        chk(tag, {req, wb_cyc_o, wb_stb_o, out_flit_valid, err_pkt, err_code}, {4'b0000, ep, ec});
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] scan_adr [4];
        int          early;
        scan_adr[0] = 32'h0010_8000;
        scan_adr[1] = 32'h0010_2000;
        scan_adr[2] = 32'h0010_4000;
        scan_adr[3] = 32'h0010_6000;

        rst_debug_n = 1'b0;
        rst_sys     = 1'b0;
        irq_tdm     = 1'b0;
        irq_be      = 1'b0;
        enable      = 1'b0;
        wb_ack_i    = 1'b0;
        wb_err_i    = 1'b0;
        wb_dat_i    = '0;
        buf_free    = 5'd16;
        repeat (3) tick();
        @(negedge clk);
        chk("reset_outputs", {req, wb_cyc_o, wb_stb_o, out_flit_valid, out_flit_last, out_flit_16,
                              err_pkt, err_code, wb_adr_o}, 0);
        tick();
        rst_debug_n = 1'b1;

        // T4: admission threshold and rst_sys blocking
        irq_tdm  = 1'b1;
        buf_free = 5'd10;
        @(negedge clk);
        chk("t4_req_free10", req, 0);
        tick();
        buf_free = 5'd11;
        @(negedge clk);
        chk("t4_req_free11", req, 1);
        tick();
        buf_free = 5'd16;
        rst_sys  = 1'b1;
        @(negedge clk);
        chk("t4_req_rstsys", req, 0);
        tick();
        rst_sys = 1'b0;
        idle_check("t4_idle", 0, 2'd0);

        // T1: TDM scan ep0 empty, ep1 size 3
        start(1'b1);
        bus(1'b1, 1'b0, 32'd0);
        chk("t1_bus_active", {req, wb_cyc_o, wb_stb_o}, 3'b111);
        chk("t1_adr_ep0", wb_adr_o, 32'h0020_2000);
        chk("t1_scan_noflit", out_flit_valid, 0);
        tick();
        bus(1'b1, 1'b0, 32'd3);
        chk("t1_adr_ep1", wb_adr_o, 32'h0020_4000);
        chk("t1_header", flit(), mk(1, 0, 1, 32'h8001));
        tick();
        for (int i = 1; i <= 3; i++) begin
            bus(1'b1, 1'b0, 32'hA0 + 32'(i));
            chk("t1_data", flit(), mk(1, (i == 3), 0, 32'hA0 + 32'(i)));
            tick();
        end
        idle_check("t1_idle", 0, 2'd0);

        // T2: BE round-robin over 4 endpoints
        start(1'b0);
        bus(1'b1, 1'b0, 32'd1);
        chk("t2_adr_ep0", wb_adr_o, 32'h0010_2000);
        chk("t2_hdr_ep0", flit(), mk(1, 0, 1, 32'h0000));
        tick();
        bus(1'b1, 1'b0, 32'h11);
        chk("t2_data_ep0", flit(), mk(1, 1, 0, 32'h11));
        tick();
        idle_check("t2_idle_a", 0, 2'd0);
        start(1'b0);
        bus(1'b1, 1'b0, 32'd0);
        chk("t2_rr_starts_ep1", wb_adr_o, 32'h0010_4000);
        tick();
        bus(1'b1, 1'b0, 32'd1);
        chk("t2_adr_ep2", wb_adr_o, 32'h0010_6000);
        chk("t2_hdr_ep2", flit(), mk(1, 0, 1, 32'h0002));
        tick();
        bus(1'b1, 1'b0, 32'h22);
        chk("t2_data_ep2", flit(), mk(1, 1, 0, 32'h22));
        tick();
        idle_check("t2_idle_b", 0, 2'd0);
        start(1'b0);
        for (int k = 0; k < 4; k++) begin
            bus(1'b1, 1'b0, 32'd0);
            chk("t2_scan_adr", wb_adr_o, scan_adr[k]);
            chk("t2_scan_noflit", out_flit_valid, 0);
            tick();
        end
        idle_check("t2_full_scan_idle", 0, 2'd0);

        // T3: oversize packet, truncation and discard
        start(1'b1);
        bus(1'b1, 1'b0, 32'd14);
        chk("t3_adr_ep0", wb_adr_o, 32'h0020_2000);
        chk("t3_header", flit(), mk(1, 0, 1, 32'h8000));
        chk("t3_err_not_yet", err_pkt, 0);
        tick();
        for (int i = 1; i <= 10; i++) begin
            bus(1'b1, 1'b0, 32'(i));
            chk("t3_data", flit(), mk(1, (i == 10), 0, 32'(i)));
            chk("t3_err", {err_pkt, err_code}, (i == 1) ? 3'b101 : 3'b000);
            tick();
        end
        for (int j = 0; j < 4; j++) begin
            bus(1'b1, 1'b0, 32'hEE);
            chk("t3_discard", {out_flit_valid, wb_cyc_o, err_pkt}, 3'b010);
            tick();
        end
        idle_check("t3_idle", 0, 2'd0);

        // T5: bus error on second payload read, then normal BE packet
        start(1'b1);
        bus(1'b1, 1'b0, 32'd5);
        chk("t5_adr_ep1", wb_adr_o, 32'h0020_4000);
        chk("t5_header", flit(), mk(1, 0, 1, 32'h8001));
        tick();
        bus(1'b1, 1'b0, 32'h55);
        chk("t5_data1", flit(), mk(1, 0, 0, 32'h55));
        tick();
        bus(1'b1, 1'b1, 32'hDEAD);
        chk("t5_err_flit", flit(), mk(1, 1, 0, 32'h0));
        tick();
        idle_check("t5_err_report", 1, 2'd2);
        start(1'b0);
        bus(1'b1, 1'b0, 32'd1);
        chk("t5_adr_ep3", wb_adr_o, 32'h0010_8000);
        chk("t5_hdr_ep3", flit(), mk(1, 0, 1, 32'h0003));
        tick();
        bus(1'b1, 1'b0, 32'h77);
        chk("t5_data_ep3", flit(), mk(1, 1, 0, 32'h77));
        tick();
        idle_check("t5_idle", 0, 2'd0);

        // T6a: ack never arrives in READ
        start(1'b0);
        bus(1'b1, 1'b0, 32'd4);
        chk("t6_adr_ep0", wb_adr_o, 32'h0010_2000);
        chk("t6_header", flit(), mk(1, 0, 1, 32'h0000));
        tick();
        early = 0;
        for (int k = 0; k < TMO - 1; k++) begin
            bus(1'b0, 1'b0, 32'd0);
            early += int'(out_flit_valid);
            tick();
        end
        chk("t6_no_early_abort", early, 0);
        bus(1'b0, 1'b0, 32'd0);
        chk("t6_timeout_flit", flit(), mk(1, 1, 0, 32'h0));
        tick();
        idle_check("t6_timeout_report", 1, 2'd3);

        // T6b: rst_sys together with a bus error mid-READ
        start(1'b0);
        bus(1'b1, 1'b0, 32'd3);
        chk("t6_adr_ep1", wb_adr_o, 32'h0010_4000);
        chk("t6_hdr_ep1", flit(), mk(1, 0, 1, 32'h0001));
        tick();
        bus(1'b1, 1'b0, 32'h31);
        chk("t6_data1", flit(), mk(1, 0, 0, 32'h31));
        tick();
        rst_sys = 1'b1;
        bus(1'b1, 1'b1, 32'h32);
        chk("t6_rst_flit", flit(), mk(1, 1, 0, 32'h0));
        tick();
        idle_check("t6_rst_idle_no_err", 0, 2'd0);
        rst_sys = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
